// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream-format constants for the instruction-memory boot loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_e;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_word_pack.sv
// imem_word_pack: big-endian 8->32 shift packer; word_valid fires combinationally with the 4th byte of each word.
module imem_word_pack
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt_q;
    logic [23:0] sh_q;

    assign word_valid = in_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word       = {sh_q, in_byte};

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else if (in_valid) begin
            cnt_q <= cnt_q + 2'd1;
            sh_q  <= {sh_q[15:0], in_byte};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader writing big-endian words to instruction memory while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_FIN = S_CHECK;
    logic [7:0] xor_q;
`else
    localparam state_e S_FIN = S_DONE;
`endif
    state_e            state_q, state_d;
    logic [7:0]        len_hi_q;
    logic [15:0]       cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, word;
    logic              we_q, acc, restart, last_wr, wv;
    logic [15:0]       n;

    assign acc     = byte_valid && byte_ready;
    assign restart = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign last_wr = we_q && (cnt_q == 16'd1);
    assign n       = {len_hi_q, byte_data};

    imem_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .in_valid   (acc && state_q == S_DATA),
        .in_byte    (byte_data),
        .word_valid (wv),
        .word       (word)
    );

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_d = (n == '0) ? S_FIN : (n > 16'(DEPTH)) ? S_ERROR : S_DATA;
            end
            // Stall the stream for the final write so no byte past the payload is taken as data.
            S_DATA: begin
                byte_ready = !last_wr;
                if (last_wr) state_d = S_FIN;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_d = (byte_data == xor_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= wv;
            if (wv) wdata_q <= word;
            if (acc && state_q == S_LEN_HI) len_hi_q <= byte_data;
            if (restart) addr_q <= '0;
            else if (we_q) addr_q <= addr_q + 1'b1;
            if (restart) cnt_q <= '0;
            else if (acc && state_q == S_LEN_LO) cnt_q <= n;
            else if (we_q) cnt_q <= cnt_q - 16'd1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst || restart) xor_q <= '0;
        else if (acc && state_q == S_DATA) xor_q <= xor_q ^ byte_data;
    end
`endif

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign cpu_hold   = (state_q != S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream stimulus checked against an image-level reference of the expected writes.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0, rst, start, byte_valid, byte_ready;
    logic [7:0]        byte_data;
    logic              imem_we, cpu_hold, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log: every strobe seen, with its cycle stamp.
    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    int                wc[$];
    always @(negedge clk) if (imem_we) begin
        wa.push_back(imem_addr);
        wd.push_back(imem_wdata);
        wc.push_back(cyc);
    end

    int errors = 0, checks = 0, end_cyc = 0;
    logic [31:0] img[$];
    logic [7:0]  stream[$];
    int          acc_c[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream = big-endian word count, payload MSB first, then XOR trailer when checksumming.
    task automatic build(input bit bad);
        logic [7:0] x = 8'h00;
        logic [15:0] len = 16'(img.size());
        stream = {};
        stream.push_back(len[15:8]);
        stream.push_back(len[7:0]);
        foreach (img[k]) for (int b = 3; b >= 0; b--) begin
            stream.push_back(img[k][8*b +: 8]);
            x ^= img[k][8*b +: 8];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(bad ? (x ^ 8'h01) : x);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send(input bit gaps, input int nb);
        int i = 0, guard = 0;
        acc_c = {};
        while (i < nb && guard < 2000) begin
            @(negedge clk);
            guard++;
            byte_valid = gaps ? ($urandom_range(1) == 1) : 1'b1;
            byte_data  = stream[i];
            if (byte_valid && byte_ready) begin
                acc_c.push_back(cyc);
                i++;
            end
        end
        @(negedge clk) byte_valid = 1'b0;
        if (i < nb) chk("send_timeout", 64'(i), 64'(nb));
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || error) && t < 400) begin
            @(negedge clk);
            t++;
        end
        end_cyc = cyc;
        if (t >= 400) chk("end_timeout", 0, 1);
    endtask

    task automatic run_image(input string tag, input bit gaps, input bit bad, input bit timing);
        int base = wa.size();
        int nw;
        build(bad);
        pulse_start();
        send(gaps, stream.size());
        wait_end();
        nw = wa.size() - base;
        chk({tag, ":nwr"}, 64'(nw), 64'(img.size()));
        for (int k = 0; k < img.size() && k < nw; k++) begin
            chk({tag, ":addr"}, 64'(wa[base+k]), 64'(k));
            chk({tag, ":data"}, 64'(wd[base+k]), 64'(img[k]));
            if (timing) chk({tag, ":we_lat"}, 64'(wc[base+k]), 64'(acc_c[2+4*k+3] + 1));
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (timing && nw > 0) chk({tag, ":done_lat"}, 64'(end_cyc), 64'(wc[wa.size()-1] + 1));
`endif
        chk({tag, ":done"}, 64'(done), 64'(!bad));
        chk({tag, ":error"}, 64'(error), 64'(bad));
        chk({tag, ":hold"}, 64'(cpu_hold), 64'(bad));
        chk({tag, ":ready"}, 64'(byte_ready), 0);
    endtask

    task automatic rand_img(input int n);
        img = {};
        repeat (n) img.push_back($urandom);
    endtask

    initial begin
        int base;
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst:ready", 64'(byte_ready), 0);
        chk("rst:we", 64'(imem_we), 0);
        chk("rst:addr", 64'(imem_addr), 0);
        chk("rst:wdata", 64'(imem_wdata), 0);
        chk("rst:done", 64'(done), 0);
        chk("rst:error", 64'(error), 0);
        chk("rst:hold", 64'(cpu_hold), 1);
        rst = 1'b1;

        img = '{32'h24080005, 32'h08000000};
        run_image("basic", 0, 0, 1);

        img = {};
        run_image("zero", 0, 0, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        chk("zero:lat_le2", 64'(end_cyc - acc_c[1] <= 2), 1);
`endif

        base = wa.size();
        stream = '{8'h01, 8'h01};
        pulse_start();
        send(0, 2);
        repeat (2) @(negedge clk);
        chk("big:error", 64'(error), 1);
        chk("big:hold", 64'(cpu_hold), 1);
        chk("big:ready", 64'(byte_ready), 0);
        chk("big:done", 64'(done), 0);
        repeat (5) @(negedge clk) begin byte_valid = 1'b1; byte_data = 8'hA5; end
        @(negedge clk) byte_valid = 1'b0;
        chk("big:nwr", 64'(wa.size() - base), 0);
        chk("big:still_err", 64'(error), 1);

        rand_img(3);
        run_image("gaps", 1, 0, 0);

        base = wa.size();
        repeat (4) @(negedge clk) begin byte_valid = 1'b1; byte_data = 8'h5A; end
        @(negedge clk) byte_valid = 1'b0;
        chk("idle_valid:nwr", 64'(wa.size() - base), 0);
        chk("idle_valid:done", 64'(done), 1);

        rand_img(2);
        build(0);
        base = wa.size();
        pulse_start();
        send($urandom_range(1) == 1, 8);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst:partial", 64'(wa.size() - base), 1);
        chk("midrst:hold", 64'(cpu_hold), 1);
        chk("midrst:ready", 64'(byte_ready), 0);
        chk("midrst:done", 64'(done), 0);
        chk("midrst:addr", 64'(imem_addr), 0);
        rst = 1'b1;
        rand_img(1);
        run_image("after_rst", 0, 0, 0);

        for (int r = 0; r < 4; r++) begin
            rand_img($urandom_range(1, 6));
            run_image($sformatf("rand%0d", r), $urandom_range(1) == 1, 0, 0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{32'h12345678};
        run_image("csum_ok", 0, 0, 0);
        run_image("csum_bad", 0, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
